// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-to-UART reporter: defaults, state encoding
// and frame-size helpers.
package bip_pkg;

  localparam int NB_DATA_DEF = 16;
  localparam int NB_PC_DEF = 11;
  localparam int NB_OPCODE_DEF = 5;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam logic [NB_OPCODE_DEF-1:0] HALT_OPCODE_DEF = 5'b00000;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  // Bytes needed to carry an nb-bit field.
  function automatic int nby(input int nb);
    return (nb + 7) / 8;
  endfunction

  // HEADER + PC + ACC + INSTR + CHK.
  function automatic int frame_len(input int nb_pc, input int nb_data);
    return 2 + nby(nb_pc) + 2 * nby(nb_data);
  endfunction

endpackage

// File: rtl/bip_uart_reporter_if.sv
// BIP-side and UART-side signals of the reporter, with the reporter as slave.
interface bip_uart_reporter_if
  import bip_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_PC = NB_PC_DEF
) ();

  // UART handshake: o_tx_start pulses for one cycle with o_data already valid;
  // o_data then holds until i_tx_done is seen while waiting for it, and
  // i_tx_done at any other time (including the tx_start cycle) is ignored.
  logic               i_mode;
  logic [NB_PC-1:0]   i_pc;
  logic [NB_DATA-1:0] i_acc;
  logic [NB_DATA-1:0] i_instruction;
  logic               i_tx_done;
  logic               o_valid;
  logic [7:0]         o_data;
  logic               o_tx_start;
  logic               o_busy;
  state_e             dbg_state;

  modport master (
    output i_mode, i_pc, i_acc, i_instruction, i_tx_done,
    input  o_valid, o_data, o_tx_start, o_busy, dbg_state
  );

  modport slave (
    input  i_mode, i_pc, i_acc, i_instruction, i_tx_done,
    output o_valid, o_data, o_tx_start, o_busy, dbg_state
  );

endinterface

// File: rtl/bip_frame_mux.sv
// Selects frame byte idx from the snapshot: HEADER, PC, ACC, INSTR (MSB byte
// first, zero-padded at the top), then CHK.
module bip_frame_mux
  import bip_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_PC = NB_PC_DEF,
  parameter int FRAME_LEN = frame_len(NB_PC, NB_DATA),
  parameter int IDX_W = $clog2(FRAME_LEN)
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [7:0]         header,
  input  logic [NB_PC-1:0]   pc,
  input  logic [NB_DATA-1:0] acc,
  input  logic [NB_DATA-1:0] instr,
  input  logic [7:0]         chk,
  output logic [7:0]         data
);

  localparam int NBY_PC = nby(NB_PC);
  localparam int NBY_D = nby(NB_DATA);

  logic [NBY_PC*8-1:0]    pc_pad;
  logic [NBY_D*8-1:0]     acc_pad;
  logic [NBY_D*8-1:0]     instr_pad;
  logic [FRAME_LEN*8-1:0] frame;

  always_comb begin
    pc_pad = '0;
    pc_pad[NB_PC-1:0] = pc;
    acc_pad = '0;
    acc_pad[NB_DATA-1:0] = acc;
    instr_pad = '0;
    instr_pad[NB_DATA-1:0] = instr;
  end

  // Byte 0 sits in the top lane so the frame reads left to right.
  assign frame = {header, pc_pad, acc_pad, instr_pad, chk};

  always_comb begin
    data = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (idx == IDX_W'(k)) data = frame[(FRAME_LEN-1-k)*8 +: 8];
    end
  end

endmodule

// File: rtl/bip_uart_reporter.sv
// Gates BIP execution, snapshots PC/ACC/INSTR and streams them to uart_tx as
// a HEADER-prefixed, XOR-checksummed frame. Supports run-to-halt and single-step.
module bip_uart_reporter
  import bip_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_PC = NB_PC_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input logic                i_clock,
  input logic                i_reset,
  bip_uart_reporter_if.slave bus
);

  localparam int FRAME_LEN = frame_len(NB_PC, NB_DATA);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e             state;
  logic [IDX_W-1:0]   cnt;
  logic [IDX_W-1:0]   mux_idx;
  logic [7:0]         chk;
  logic [7:0]         mux_byte;
  logic [7:0]         data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               halt_flag;
  logic               halt_det;
  logic [NB_PC-1:0]   snap_pc;
  logic [NB_DATA-1:0] snap_acc;
  logic [NB_DATA-1:0] snap_instr;

  assign halt_det = (bus.i_instruction[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE);

  // o_data is registered, so the mux looks at the byte about to be sent.
  assign mux_idx = (state == ST_CAPTURE) ? '0 : cnt + IDX_W'(1);

  bip_frame_mux #(
    .NB_DATA(NB_DATA),
    .NB_PC  (NB_PC)
  ) u_frame_mux (
    .idx   (mux_idx),
    .header(HEADER),
    .pc    (snap_pc),
    .acc   (snap_acc),
    .instr (snap_instr),
    .chk   (chk),
    .data  (mux_byte)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_RUN;
      cnt        <= '0;
      chk        <= '0;
      data_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      halt_flag  <= 1'b0;
      snap_pc    <= '0;
      snap_acc   <= '0;
      snap_instr <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (halt_det || bus.i_mode) begin
            state  <= ST_CAPTURE;
            busy_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          snap_pc    <= bus.i_pc;
          snap_acc   <= bus.i_acc;
          snap_instr <= bus.i_instruction;
          halt_flag  <= halt_det;
          cnt        <= '0;
          chk        <= '0;
          data_q     <= mux_byte;
          tx_start_q <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          // HEADER and the checksum byte itself stay out of the checksum.
          if (cnt != '0 && cnt != LAST_IDX) chk <= chk ^ data_q;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.i_tx_done) begin
            if (cnt == LAST_IDX) begin
              state  <= ST_FINISH;
              busy_q <= 1'b0;
            end else begin
              cnt        <= mux_idx;
              data_q     <= mux_byte;
              tx_start_q <= 1'b1;
              state      <= ST_SEND;
            end
          end
        end
        ST_FINISH: state <= halt_flag ? ST_HALTED : ST_RUN;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Combinational so the halt instruction itself is never enabled.
  assign bus.o_valid    = !i_reset && (state == ST_RUN) && !halt_det;
  assign bus.o_data     = data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.dbg_state  = state;

endmodule

// File: doc/bip_uart_reporter.md
Name: bip_uart_reporter

Overview:
Parametrised successor to the BIP-to-UART interface. It gates BIP execution through a valid strobe, snapshots PC, ACC and instruction, and sends them as a framed, checksummed byte stream to uart_tx over the tx_start/tx_done handshake. It sits between bip_BIP and uart_tx in top_level. Data and PC widths are generalised, and it adds a run-to-halt mode and a single-step mode.

Parameters:
NB_DATA, 16, width of ACC and instruction words
NB_PC, 11, width of program counter
NB_OPCODE, 5, opcode field width; the opcode is the instruction MSBs [NB_DATA-1 -: NB_OPCODE]
HALT_OPCODE, 5'b00000, opcode value that marks halt
HEADER, 8'hA5, first byte of every frame

Ports:
i_clock  in  1  single system clock
i_reset  in  1  synchronous, active-high reset
i_mode  in  1  0 = run-to-halt, 1 = single-step; sampled only in RUN
i_pc  in  NB_PC  BIP program counter
i_acc  in  NB_DATA  BIP accumulator
i_instruction  in  NB_DATA  BIP current instruction
i_tx_done  in  1  uart_tx byte-complete pulse
o_valid  out  1  BIP execute enable
o_data  out  8  byte to uart_tx
o_tx_start  out  1  one-cycle transmit request
o_busy  out  1  high while a frame is in flight

Behaviour:
- Derived constants:
  - NBY_PC = (NB_PC+7)/8 and NBY_D = (NB_DATA+7)/8.
  - Frame length L = 2 + NBY_PC + 2*NBY_D bytes.
- Frame order:
  - HEADER first.
  - Then PC, ACC and INSTR, each MSB byte first and zero-padded at the top.
  - Then CHK, the XOR of all payload bytes (HEADER excluded).
- halt_det = (i_instruction opcode field == HALT_OPCODE). It is combinational.
- Reset values: state=RUN, o_valid=0, o_data=0, o_tx_start=0, o_busy=0, byte counter=0, checksum=0.
- Reset behaviour: reset applies on any clock edge where i_reset=1, including mid-frame. A partial frame is abandoned with no further tx_start.
- States and transitions:
  - RUN:
    - o_valid = !halt_det (combinational, so the halt instruction never executes).
    - Mode 0: stay in RUN until halt_det, then go to CAPTURE.
    - Mode 1: o_valid is high for exactly one cycle (if !halt_det), then go to CAPTURE. If halt_det, go to CAPTURE with o_valid=0.
  - CAPTURE (1 cycle):
    - o_valid=0.
    - Latch {i_pc, i_acc, i_instruction} into a snapshot register, so later input changes are ignored.
    - Latch halt flag = halt_det.
    - Clear the counter and checksum. Set o_busy=1. Go to SEND.
  - SEND (1 cycle):
    - o_data = byte[counter]; o_tx_start=1 for this cycle only.
    - For payload bytes, checksum ^= byte.
    - Go to WAIT_DONE.
  - WAIT_DONE:
    - o_data is held stable.
    - On i_tx_done: if counter==L-1, go to FINISH; otherwise counter++ and go to SEND.
    - i_tx_done is ignored in every other state.
  - FINISH (1 cycle):
    - o_busy=0.
    - If the halt flag is set, go to HALTED; else if mode 1, go to RUN; else go to RUN (mode 0 cannot reach here without halt).
  - HALTED: o_valid=0. Remain here until reset.
- Latency:
  - CAPTURE to first tx_start is 1 cycle.
  - The next tx_start follows i_tx_done by 1 cycle.
  - Total frame time ≈ L*(byte time + 1).
- Boundary cases:
  - tx_done arriving in the same cycle as tx_start (SEND) is ignored.
  - i_mode toggling mid-frame has no effect until the next RUN.
  - Widths that are exact multiples of 8 get no padding byte.

Decomposition:
- Shared package bip_pkg holds:
  - state encoding localparams;
  - NBY_PC, NBY_D and L calculation functions;
  - HEADER and HALT_OPCODE defaults.
- One sub-module, bip_frame_mux: combinational byte selection from the snapshot by index, including zero padding.
- The FSM, counter and checksum stay in bip_uart_reporter.

Test Plan:
1. Mode 0, defaults; BIP runs 3 cycles, then instruction=16'h0000 with pc=3, acc=16'h1234.
   - Required response: o_valid high 3 cycles, low on the halt cycle.
   - Bytes: A5 00 03 12 34 00 00 CHK=0x25; state HALTED; o_busy=0.
2. Mode 1, pc=11'h7FF, acc=16'hFFFF, instr=16'h0801 (non-halt).
   - Required response: single o_valid pulse.
   - Frame: A5 07 FF FF FF 08 01, CHK = 07^FF^FF^FF^08^01 = 0xF1.
   - Then returns to RUN, giving exactly one o_valid pulse per frame.
3. Handshake: hold i_tx_done low for 50 cycles after a tx_start.
   - o_data stays stable and no second tx_start occurs.
   - A spurious tx_done during SEND does not advance the counter.
4. Reset asserted after the 3rd byte of a frame.
   - The next cycle has all outputs zero and state RUN.
   - No further tx_start occurs until a new CAPTURE.
5. Parametric run with NB_DATA=8, NB_PC=8.
   - L=5; frame A5 pc acc instr CHK; checksum correct for random snapshots (self-checking model, 100 frames).
6. Inputs change during WAIT_DONE.
   - Transmitted bytes match the snapshot taken in CAPTURE, not the live inputs.
